// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared fetch-path defines and default PC generator constants.
package pc_gen_pkg;
    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;
    localparam logic Branch      = 1'b1;
    localparam logic NotBranch   = 1'b0;
    localparam logic RstEnable   = 1'b1;
    localparam int   InstAddrBus = 32;
    localparam logic [InstAddrBus-1:0] ZeroWord = '0;
    localparam int   DEF_ADDR_W = InstAddrBus;
    localparam logic [InstAddrBus-1:0] DEF_RESET_VECTOR = ZeroWord;
endpackage

// File: rtl/pc_gen.sv
// pc_gen: IF-stage fetch PC with reset vector, stall, flush and a one-deep buffered branch.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int INST_BYTES = 4,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEF_RESET_VECTOR)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] flush_pc_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_addr_i,
    output logic [ADDR_W-1:0] pc,
    output logic              ce,
    output logic              redirect_pending_o,
    output logic              misalign_o
);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INST_BYTES - 1);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INST_BYTES);

    logic [ADDR_W-1:0] pc_q, pc_d, pend_a_q, pend_a_d;
    logic              ce_q, pend_v_q, pend_v_d;

    always_comb begin
        pc_d = pc_q;
        pend_v_d = pend_v_q;
        pend_a_d = pend_a_q;
        if (ce_q == ChipDisable) begin
            pc_d = RESET_VECTOR;
            pend_v_d = 1'b0;
        end else if (flush_i) begin
            pc_d = flush_pc_i;
            pend_v_d = 1'b0;
        end else if (stall_i) begin
            // a later branch in the same stall overwrites the buffered one
            if (branch_flag_i == Branch) begin
                pend_v_d = 1'b1;
                pend_a_d = branch_target_addr_i;
            end
        end else if (branch_flag_i != NotBranch) begin
            pc_d = branch_target_addr_i;
            pend_v_d = 1'b0;
        end else if (pend_v_q) begin
            pc_d = pend_a_q;
            pend_v_d = 1'b0;
        end else begin
            pc_d = pc_q + STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            ce_q <= ChipDisable;
            pc_q <= RESET_VECTOR;
            pend_v_q <= 1'b0;
            pend_a_q <= ADDR_W'(ZeroWord);
        end else begin
            ce_q <= ChipEnable;
            pc_q <= pc_d;
            pend_v_q <= pend_v_d;
            pend_a_q <= pend_a_d;
        end
    end

    assign pc = pc_q;
    assign ce = ce_q;
    assign redirect_pending_o = pend_v_q;
    assign misalign_o = |(pc_q & ALIGN_MASK);
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed stimulus on a 32-bit and an 8-bit pc_gen, checked against a behavioural model.
module tb_pc_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, stall = 1'b0, fl = 1'b0, br = 1'b0;
    logic [31:0] fpc = '0, bt = '0, pc;
    logic        ce, pend, mis;

    logic        rst8 = 1'b1, stall8 = 1'b0, fl8 = 1'b0, br8 = 1'b0;
    logic [7:0]  fpc8 = '0, bt8 = '0, pc8;
    logic        ce8, pend8, mis8;

    pc_gen #(.ADDR_W(32), .INST_BYTES(4), .RESET_VECTOR(32'hBFC0_0000)) dut (
        .clk(clk), .rst(rst), .stall_i(stall), .flush_i(fl), .flush_pc_i(fpc),
        .branch_flag_i(br), .branch_target_addr_i(bt), .pc(pc), .ce(ce),
        .redirect_pending_o(pend), .misalign_o(mis));

    pc_gen #(.ADDR_W(8), .INST_BYTES(4), .RESET_VECTOR(8'hF0)) dut8 (
        .clk(clk), .rst(rst8), .stall_i(stall8), .flush_i(fl8), .flush_pc_i(fpc8),
        .branch_flag_i(br8), .branch_target_addr_i(bt8), .pc(pc8), .ce(ce8),
        .redirect_pending_o(pend8), .misalign_o(mis8));

    typedef struct packed {
        logic        ce;
        logic [31:0] pc;
        logic        pv;
        logic [31:0] pa;
    } st_t;

    int cmp = 0, bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic st_t step(input st_t s, input logic r, input logic st, input logic f,
                                 input logic b, input logic [31:0] fp, input logic [31:0] t,
                                 input logic [31:0] rv, input logic [31:0] mask);
        st_t n = s;
        if (r) begin
            n.ce = 1'b0; n.pc = rv; n.pv = 1'b0;
            return n;
        end
        n.ce = 1'b1;
        if (!s.ce) begin n.pc = rv; n.pv = 1'b0; end
        else if (f) begin n.pc = fp & mask; n.pv = 1'b0; end
        else if (st) begin if (b) begin n.pv = 1'b1; n.pa = t & mask; end end
        else if (b) begin n.pc = t & mask; n.pv = 1'b0; end
        else if (s.pv) begin n.pc = s.pa; n.pv = 1'b0; end
        else n.pc = (s.pc + 32'd4) & mask;
        return n;
    endfunction

    st_t m, m8;
    logic mv = 1'b0, mv8 = 1'b0;

    always @(posedge clk) begin
        m  <= step(m, rst, stall, fl, br, fpc, bt, 32'hBFC0_0000, 32'hFFFF_FFFF);
        m8 <= step(m8, rst8, stall8, fl8, br8, {24'h0, fpc8}, {24'h0, bt8}, 32'hF0, 32'hFF);
        mv  <= mv | rst;
        mv8 <= mv8 | rst8;
    end

    always @(negedge clk) begin
        if (mv) begin
            chk("model_pc", pc, m.pc);
            chk("model_ce", {31'h0, ce}, {31'h0, m.ce});
            chk("model_pend", {31'h0, pend}, {31'h0, m.pv});
            chk("model_mis", {31'h0, mis}, {31'h0, |m.pc[1:0]});
        end
        if (mv8) begin
            chk("model8_pc", {24'h0, pc8}, m8.pc);
            chk("model8_ce", {31'h0, ce8}, {31'h0, m8.ce});
            chk("model8_pend", {31'h0, pend8}, {31'h0, m8.pv});
            chk("model8_mis", {31'h0, mis8}, {31'h0, |m8.pc[1:0]});
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tick; tick;
        chk("rst_pc", pc, 32'hBFC0_0000);
        chk("rst_ce", {31'h0, ce}, 32'd0);
        chk("rst_pend", {31'h0, pend}, 32'd0);
        chk("rst_mis", {31'h0, mis}, 32'd0);
        rst = 1'b0;
        tick; chk("rel_ce", {31'h0, ce}, 32'd1); chk("rel_pc0", pc, 32'hBFC0_0000);
        tick; chk("rel_pc1", pc, 32'hBFC0_0004);
        tick; chk("rel_pc2", pc, 32'hBFC0_0008);
        br = 1'b1; bt = 32'h10;
        tick; chk("br_to10", pc, 32'h10);
        bt = 32'h100;
        tick; chk("br_100", pc, 32'h100);
        br = 1'b0;
        tick; chk("br_seq", pc, 32'h104);
        br = 1'b1; bt = 32'h20;
        tick; br = 1'b0; chk("br_to20", pc, 32'h20);
        stall = 1'b1;
        tick; chk("st1_pc", pc, 32'h20); chk("st1_pend", {31'h0, pend}, 32'd0);
        br = 1'b1; bt = 32'h200;
        tick; chk("st2_pc", pc, 32'h20); chk("st2_pend", {31'h0, pend}, 32'd1);
        br = 1'b0;
        tick; chk("st3_pc", pc, 32'h20); chk("st3_pend", {31'h0, pend}, 32'd1);
        stall = 1'b0;
        tick; chk("unst_pc", pc, 32'h200); chk("unst_pend", {31'h0, pend}, 32'd0);
        tick; chk("unst_seq", pc, 32'h204);
        fl = 1'b1; fpc = 32'h180; br = 1'b1; bt = 32'h300;
        tick; chk("flbr_pc", pc, 32'h180); chk("flbr_pend", {31'h0, pend}, 32'd0);
        fl = 1'b0; br = 1'b0;
        tick; chk("fl_seq", pc, 32'h184);
        stall = 1'b1; br = 1'b1; bt = 32'h400;
        tick; chk("stbr_pend", {31'h0, pend}, 32'd1); chk("stbr_pc", pc, 32'h184);
        fl = 1'b1; fpc = 32'h180; bt = 32'h300;
        tick; chk("stfl_pc", pc, 32'h180); chk("stfl_pend", {31'h0, pend}, 32'd0);
        fl = 1'b0; br = 1'b0; stall = 1'b0;
        tick; chk("stfl_seq", pc, 32'h184);
        stall = 1'b1; br = 1'b1; bt = 32'h500;
        tick; stall = 1'b0; bt = 32'h600;
        tick; chk("live_pc", pc, 32'h600); chk("live_pend", {31'h0, pend}, 32'd0);
        br = 1'b0;
        tick; chk("live_seq", pc, 32'h604);
        stall = 1'b1; br = 1'b1; bt = 32'h700;
        tick; chk("prst_pend", {31'h0, pend}, 32'd1);
        rst = 1'b1; br = 1'b0;
        tick;
        chk("mrst_ce", {31'h0, ce}, 32'd0); chk("mrst_pc", pc, 32'hBFC0_0000);
        chk("mrst_pend", {31'h0, pend}, 32'd0);
        rst = 1'b0; fl = 1'b1; fpc = 32'h180; br = 1'b1; bt = 32'h300;
        tick;
        chk("cedis_ce", {31'h0, ce}, 32'd1); chk("cedis_pc", pc, 32'hBFC0_0000);
        chk("cedis_pend", {31'h0, pend}, 32'd0);
        fl = 1'b0; br = 1'b0; stall = 1'b0;
        tick; chk("cedis_seq", pc, 32'hBFC0_0004);
        rst8 = 1'b0;
        tick; chk("w8_ce", {31'h0, ce8}, 32'd1); chk("w8_pc0", {24'h0, pc8}, 32'hF0);
        tick; chk("w8_pc1", {24'h0, pc8}, 32'hF4);
        tick; chk("w8_pc2", {24'h0, pc8}, 32'hF8);
        tick; chk("w8_pcFC", {24'h0, pc8}, 32'hFC);
        tick; chk("w8_wrap", {24'h0, pc8}, 32'h00);
        br8 = 1'b1; bt8 = 8'h02;
        tick; chk("w8_mis_pc", {24'h0, pc8}, 32'h02); chk("w8_mis", {31'h0, mis8}, 32'd1);
        br8 = 1'b0;
        tick; chk("w8_mis_seq", {24'h0, pc8}, 32'h06); chk("w8_mis2", {31'h0, mis8}, 32'd1);
        tick;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the IF stage: the next generation of the fetch PC register. It adds a configurable reset vector, address width and instruction size, and honours a pipeline stall. A branch redirect that arrives during a stall is buffered and applied once the stall clears. Exception flush takes priority over branches. It drives the instruction-memory address and chip enable, and takes redirects from ID (branch) and the control unit (stall/flush).

## Interface
- ADDR_W, 32, PC and target width in bits
- INST_BYTES, 4, PC increment per sequential fetch; power of two, ≥1
- RESET_VECTOR, 32'h0000_0000, PC value held while fetch is disabled

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stall_i  in  1  hold PC (pipeline stall from control unit)
- flush_i  in  1  exception/flush redirect, highest priority after reset
- flush_pc_i  in  ADDR_W  flush target (exception handler / EPC)
- branch_flag_i  in  1  branch/jump taken, from ID
- branch_target_addr_i  in  ADDR_W  branch target, from ID
- pc  out  ADDR_W  current fetch address, registered
- ce  out  1  instruction-memory chip enable, registered
- redirect_pending_o  out  1  a buffered branch is waiting for stall release
- misalign_o  out  1  pc low log2(INST_BYTES) bits nonzero (combinational from pc)

## Operation
- Per posedge, priority order:
  - rst: ce←ChipDisable; pc←RESET_VECTOR; pending valid←0.
  - Otherwise ce←ChipEnable.
  - If ce is currently disabled: pc←RESET_VECTOR. Flush, branch and stall are ignored and pending stays 0.
  - Else if flush_i: pc←flush_pc_i; pending cleared. Applies regardless of stall.
  - Else if stall_i: pc held. If branch_flag_i, then pending valid←1 and pending addr←branch_target_addr_i. A later branch during the same stall overwrites the earlier one.
  - Else if branch_flag_i: pc←branch_target_addr_i; pending cleared. A live branch beats a buffered one.
  - Else if pending valid: pc←pending addr; pending valid←0.
  - Else pc←pc+INST_BYTES, modulo 2^ADDR_W. Wraps from all-ones region to 0 silently.
- redirect_pending_o = pending valid register.
- Targets are not masked. A misaligned target is loaded as given, and misalign_o flags it for the exception logic.

## Timing
- Reset values: pc=RESET_VECTOR, ce=0, redirect_pending_o=0, misalign_o=0 (if RESET_VECTOR is aligned).
- Cycle after rst deasserts: ce=1 and pc=RESET_VECTOR, so the first fetch is at RESET_VECTOR. pc advances on the following edge.
- Redirect latency is 1 cycle: a flush or branch sampled at edge N makes pc=target after edge N.
- Buffered branch: applied on the first edge where stall_i=0, unless flush_i or a new branch_flag_i occurs on that same edge.
- Flush and branch on the same edge: flush wins; the branch is dropped.
- Flush during stall: pc←flush_pc_i immediately; any pending branch is discarded.
- rst mid-operation: returns to the reset state on the next edge; pending is lost.

## Structure
- Shared defines package holds ChipEnable/ChipDisable, Branch/NotBranch, RstEnable, ZeroWord and InstAddrBus. The package supplies the default ADDR_W and RESET_VECTOR constants.
- Single module; no sub-module needed. The pending buffer is one valid bit plus one ADDR_W register inside pc_gen.

## Test plan
- Reset release, RESET_VECTOR=32'hBFC0_0000: ce 0→1 one cycle after rst falls. pc sequence is BFC00000, BFC00000, BFC00004, BFC00008.
- Branch at pc=0x10 with target 0x100, no stall: next pc=0x100, then 0x104.
- Stall for 3 cycles at pc=0x20 with branch (target 0x200) in the stall's 2nd cycle: pc holds 0x20 and redirect_pending_o=1. The first unstalled edge gives pc=0x200 and redirect_pending_o=0.
- Same edge flush_i (0x180) and branch (0x300), with stall both high and low: pc=0x180 in both cases, and pending is cleared.
- ADDR_W=8, INST_BYTES=4, pc=0xFC: next pc=0x00. Branch to 0x02 gives misalign_o=1.
- rst asserted while pending valid: ce=0, pc=RESET_VECTOR, and redirect_pending_o=0 after the edge.
